// File: rtl/incubator_ctrl_param.sv
// Incubator climate controller: hysteresis FSM with anti-short-cycle dwell timer, sticky alarm.
// Define INCUBATOR_FAULT_SAFE_EN to force the FSM idle and the actuators off while the alarm is set.
module incubator_ctrl_param #(
  parameter int unsigned TW        = 8,
  parameter int          HEAT_ON   = 15,
  parameter int          HEAT_OFF  = 30,
  parameter int          COOL_ON   = 35,
  parameter int          COOL_OFF  = 25,
  parameter int          FAN_STEP1 = 40,
  parameter int          FAN_STEP2 = 45,
  parameter int unsigned MIN_DWELL = 4,
  parameter int          ALARM_HI  = 60,
  parameter int          ALARM_LO  = -5
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic signed [TW-1:0] T,
  input  logic                 en,
  input  logic                 alarm_clr,
  output logic                 Heater,
  output logic                 Cooler,
  output logic [3:0]           CRS,
  output logic                 OUT,
  output logic [1:0]           state,
  output logic                 alarm
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HEAT = 2'b01;
  localparam logic [1:0] ST_COOL = 2'b10;

  localparam int unsigned DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

  localparam logic signed [TW-1:0] L_HEAT_ON   = TW'(HEAT_ON);
  localparam logic signed [TW-1:0] L_HEAT_OFF  = TW'(HEAT_OFF);
  localparam logic signed [TW-1:0] L_COOL_ON   = TW'(COOL_ON);
  localparam logic signed [TW-1:0] L_COOL_OFF  = TW'(COOL_OFF);
  localparam logic signed [TW-1:0] L_FAN_STEP1 = TW'(FAN_STEP1);
  localparam logic signed [TW-1:0] L_FAN_STEP2 = TW'(FAN_STEP2);
  localparam logic signed [TW-1:0] L_ALARM_HI  = TW'(ALARM_HI);
  localparam logic signed [TW-1:0] L_ALARM_LO  = TW'(ALARM_LO);

  logic [1:0]    r_state;
  logic [1:0]    w_state_d;
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] w_dwell_d;
  logic [3:0]    r_crs;
  logic [3:0]    w_crs_d;
  logic          r_alarm;
  logic          w_alarm_d;
  logic          w_dwell_ok;
  logic          w_force_idle;
  logic          w_alarm_set;
  logic          w_act_off;

  assign w_dwell_ok  = (r_dwell == DW'(MIN_DWELL));
  assign w_alarm_set = (T > L_ALARM_HI) || (T < L_ALARM_LO);
  assign w_alarm_d   = w_alarm_set | (r_alarm & ~alarm_clr);

`ifdef INCUBATOR_FAULT_SAFE_EN
  assign w_force_idle = ~en | r_alarm;
  assign w_act_off    = r_alarm;
`else
  assign w_force_idle = ~en;
  assign w_act_off    = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dwell_ok) begin
          if (T < L_HEAT_ON)      w_state_d = ST_HEAT;
          else if (T > L_COOL_ON) w_state_d = ST_COOL;
        end
      end
      ST_HEAT: if (w_dwell_ok && (T >= L_HEAT_OFF)) w_state_d = ST_IDLE;
      ST_COOL: if (w_dwell_ok && (T <= L_COOL_OFF)) w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
    // Disable/fault override bypasses the dwell timer entirely
    if (w_force_idle) w_state_d = ST_IDLE;
  end

  always_comb begin
    w_dwell_d = r_dwell;
    if (w_force_idle || (w_state_d != r_state)) w_dwell_d = '0;
    else if (!w_dwell_ok)                       w_dwell_d = r_dwell + DW'(1);
  end

  // Fan speed follows T every cycle in COOL, independent of dwell gating
  always_comb begin
    w_crs_d = 4'd0;
    if (w_state_d == ST_COOL) begin
      if (T > L_FAN_STEP2)      w_crs_d = 4'd8;
      else if (T > L_FAN_STEP1) w_crs_d = 4'd6;
      else                      w_crs_d = 4'd4;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= ST_IDLE;
      r_dwell <= '0;
      r_crs   <= 4'd0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_dwell <= w_dwell_d;
      r_crs   <= w_crs_d;
      r_alarm <= w_alarm_d;
    end
  end

  assign Heater = (r_state == ST_HEAT) & ~w_act_off;
  assign Cooler = (r_state == ST_COOL) & ~w_act_off;
  assign CRS    = w_act_off ? 4'd0 : r_crs;
  assign OUT    = Heater | Cooler;
  assign state  = r_state;
  assign alarm  = r_alarm;

endmodule
